// File: rtl/pipe_fetch_decode.sv
// rtl/pipe_fetch_decode.sv - instruction fetch/decode stage feeding the ALU pipeline
// RAW interlock (scoreboard + bubbles) is built only when PIPE_HAZARD_STALL_EN is defined.
module pipe_fetch_decode #(
  parameter logic [7:0] BUBBLE_ADDR = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_we,
  input  logic [7:0]  imem_waddr,
  input  logic [23:0] imem_wdata,
  input  logic        start,
  input  logic [7:0]  start_pc,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [3:0]  rd,
  output logic [3:0]  func,
  output logic [7:0]  addr,
  output logic        issue_valid,
  output logic [7:0]  pc,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  localparam logic [3:0] FUNC_NOP  = 4'd3;
  localparam logic [3:0] FUNC_HALT = 4'hF;

  state_t      state_q, state_d;
  logic [23:0] imem [256];
  logic [23:0] fetch_word;
  logic [3:0]  f_func, f_rd, f_rs1, f_rs2;
  logic [7:0]  f_addr;
  logic        hazard;

  logic [7:0]  pc_d;
  logic        issue_d;
  logic [3:0]  func_d, rd_d, rs1_d, rs2_d;
  logic [7:0]  addr_d;

  // Read is combinational, write lands at the edge: a same-cycle write is not seen by the fetch.
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  assign fetch_word = imem[pc];
  assign f_func     = fetch_word[23:20];
  assign f_rd       = fetch_word[19:16];
  assign f_rs1      = fetch_word[15:12];
  assign f_rs2      = fetch_word[11:8];
  assign f_addr     = fetch_word[7:0];

`ifdef PIPE_HAZARD_STALL_EN
  // Entry 0 mirrors the slot being driven now, entry 1 the slot before it.
  logic [1:0] sb_valid;
  logic [3:0] sb_rd [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_valid <= 2'b00;
      sb_rd[0] <= 4'd0;
      sb_rd[1] <= 4'd0;
    end else begin
      sb_valid <= {sb_valid[0], issue_d};
      sb_rd[1] <= sb_rd[0];
      sb_rd[0] <= rd_d;
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (sb_valid[i] && (sb_rd[i] == f_rs1 || sb_rd[i] == f_rs2)) hazard = 1'b1;
    end
  end
`else
  assign hazard = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    issue_d = 1'b0;
    func_d  = FUNC_NOP;
    rd_d    = 4'd0;
    rs1_d   = 4'd0;
    rs2_d   = 4'd0;
    addr_d  = BUBBLE_ADDR;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = start_pc;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (f_func == FUNC_HALT) begin
          state_d = S_HALT;
        end else if (!hazard) begin
          issue_d = 1'b1;
          func_d  = f_func;
          rd_d    = f_rd;
          rs1_d   = f_rs1;
          rs2_d   = f_rs2;
          addr_d  = f_addr;
          pc_d    = pc + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc          <= 8'd0;
      issue_valid <= 1'b0;
      func        <= FUNC_NOP;
      rd          <= 4'd0;
      rs1         <= 4'd0;
      rs2         <= 4'd0;
      addr        <= BUBBLE_ADDR;
    end else begin
      state_q     <= state_d;
      pc          <= pc_d;
      issue_valid <= issue_d;
      func        <= func_d;
      rd          <= rd_d;
      rs1         <= rs1_d;
      rs2         <= rs2_d;
      addr        <= addr_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_HALT);

endmodule

// File: tb/tb_pipe_fetch_decode.sv
// tb/tb_pipe_fetch_decode.sv - self-checking bench for pipe_fetch_decode
module tb_pipe_fetch_decode;

`ifdef PIPE_HAZARD_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_we = 1'b0;
  logic [7:0]  imem_waddr = 8'd0;
  logic [23:0] imem_wdata = 24'd0;
  logic        start = 1'b0;
  logic [7:0]  start_pc = 8'd0;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr, pc;
  logic        issue_valid, busy, done;

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] mmem [256];
  int          iss_slot [$];
  logic [3:0]  iss_rd [$];
  logic [7:0]  iss_pc [$];
  int          run_cycles;

  pipe_fetch_decode dut (
    .clk(clk), .rst_n(rst_n),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .start(start), .start_pc(start_pc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
    .issue_valid(issue_valid), .pc(pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  wire [34:0] obs = {issue_valid, func, rd, rs1, rs2, addr, pc, busy, done};

  function automatic logic [23:0] enc(input logic [3:0] f, input logic [3:0] d,
                                      input logic [3:0] s1, input logic [3:0] s2,
                                      input logic [7:0] a);
    return {f, d, s1, s2, a};
  endfunction

  function automatic logic [34:0] idle_vec(input logic [7:0] p, input logic b, input logic dn);
    return {1'b0, 4'd3, 4'd0, 4'd0, 4'd0, 8'hFF, p, b, dn};
  endfunction

  task automatic write_word(input logic [7:0] a, input logic [23:0] d);
    imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
    @(negedge clk);
    imem_we = 1'b0;
    mmem[a] = d;
  endtask

  // Slot-level model: an instruction may issue only 3+ slots after the last writer of its sources.
  task automatic run_program(input logic [7:0] spc, input bit do_writes, input int wlen);
    logic [7:0]  mpc;
    int          t;
    bit          halted;
    int          last_wr [16];
    logic [23:0] w, wd;
    logic [7:0]  wa;
    logic [34:0] exp_v;
    for (int r = 0; r < 16; r++) last_wr[r] = -100;
    iss_slot.delete(); iss_rd.delete(); iss_pc.delete();
    @(negedge clk);
    start = 1'b1; start_pc = spc;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (obs !== idle_vec(spc, 1'b1, 1'b0)) begin
      miscompares++;
      $display("FAIL start_entry: got %h want %h", obs, idle_vec(spc, 1'b1, 1'b0));
    end
    mpc = spc; t = 0; halted = 1'b0;
    while (!halted && t < 300) begin
      w = mmem[mpc];
      if (w[23:20] == 4'hF) begin
        halted = 1'b1;
        exp_v = idle_vec(mpc, 1'b0, 1'b1);
      end else if (STALL && ((t - last_wr[w[15:12]] < 3) || (t - last_wr[w[11:8]] < 3))) begin
        exp_v = idle_vec(mpc, 1'b1, 1'b0);
      end else begin
        last_wr[w[19:16]] = t;
        iss_slot.push_back(t); iss_rd.push_back(w[19:16]); iss_pc.push_back(mpc);
        mpc = mpc + 8'd1;
        exp_v = {1'b1, w[23:20], w[19:16], w[15:12], w[11:8], w[7:0], mpc, 1'b1, 1'b0};
      end
      if (do_writes && !halted && ($urandom % 4 == 0)) begin
        wa = spc + 8'($urandom % wlen);
        wd = enc(4'($urandom_range(0, 14)), 4'($urandom % 4), 4'($urandom % 4),
                 4'($urandom % 4), 8'($urandom));
        imem_we = 1'b1; imem_waddr = wa; imem_wdata = wd;
        mmem[wa] = wd;
      end
      @(negedge clk);
      imem_we = 1'b0;
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL slot%0d pc_start=%h: got %h want %h", t, spc, obs, exp_v);
      end
      t++;
    end
    if (!halted) begin
      vectors++; miscompares++;
      $display("FAIL run_timeout: got no halt want halt within 300 cycles");
    end
    run_cycles = t;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (obs !== idle_vec(8'h00, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL reset_values: got %h want %h", obs, idle_vec(8'h00, 1'b0, 1'b0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs !== idle_vec(8'h00, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %h want %h", obs, idle_vec(8'h00, 1'b0, 1'b0));
    end
    for (int i = 0; i < 256; i++) write_word(8'(i), enc(4'hF, 4'd0, 4'd0, 4'd0, 8'd0));
  endtask

  task automatic test_independent();
    write_word(8'h00, enc(4'd0, 4'd1, 4'd2, 4'd3, 8'h10));
    write_word(8'h01, enc(4'd0, 4'd4, 4'd5, 4'd6, 8'h11));
    write_word(8'h02, enc(4'd1, 4'd7, 4'd8, 4'd9, 8'h12));
    write_word(8'h03, enc(4'hF, 4'd0, 4'd0, 4'd0, 8'h00));
    run_program(8'h00, 1'b0, 1);
    vectors++;
    if (iss_rd.size() != 3 || iss_rd[0] !== 4'd1 || iss_rd[1] !== 4'd4 || iss_rd[2] !== 4'd7 ||
        iss_slot[2] != 2) begin
      miscompares++;
      $display("FAIL indep_issues: got count=%0d want 3 back-to-back rd 1,4,7", iss_rd.size());
    end
    vectors++;
    if (done !== 1'b1 || pc !== 8'h03 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL indep_halt: got done=%b pc=%h busy=%b want done=1 pc=03 busy=0", done, pc, busy);
    end
  endtask

  task automatic test_raw_hazard();
    write_word(8'h00, enc(4'd0, 4'd1, 4'd2, 4'd3, 8'h20));
    write_word(8'h01, enc(4'd0, 4'd4, 4'd1, 4'd5, 8'h21));
    write_word(8'h02, enc(4'hF, 4'd0, 4'd0, 4'd0, 8'h00));
    run_program(8'h00, 1'b0, 1);
    vectors++;
    if (iss_slot.size() != 2 || (iss_slot[1] - iss_slot[0]) != (STALL ? 3 : 1)) begin
      miscompares++;
      $display("FAIL raw_spacing: got issues=%0d want 2 spaced %0d", iss_slot.size(), STALL ? 3 : 1);
    end
  endtask

  task automatic test_wrap();
    write_word(8'hFE, enc(4'd0, 4'd1, 4'd2, 4'd3, 8'h30));
    write_word(8'hFF, enc(4'd0, 4'd4, 4'd5, 4'd6, 8'h31));
    write_word(8'h00, enc(4'd1, 4'd7, 4'd8, 4'd9, 8'h32));
    write_word(8'h01, enc(4'hF, 4'd0, 4'd0, 4'd0, 8'h00));
    run_program(8'hFE, 1'b0, 1);
    vectors++;
    if (iss_pc.size() != 3 || iss_pc[0] !== 8'hFE || iss_pc[1] !== 8'hFF || iss_pc[2] !== 8'h00 ||
        pc !== 8'h01) begin
      miscompares++;
      $display("FAIL wrap_pcs: got count=%0d final pc=%h want FE,FF,00 then 01", iss_pc.size(), pc);
    end
  endtask

  task automatic test_restart();
    write_word(8'h00, enc(4'hF, 4'd0, 4'd0, 4'd0, 8'h00));
    run_program(8'h00, 1'b0, 1);
    vectors++;
    if (iss_slot.size() != 0 || run_cycles != 1 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_halt: got issues=%0d run=%0d done=%b want 0,1,1",
               iss_slot.size(), run_cycles, done);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) write_word(8'h40 + 8'(i), enc(4'd2, 4'd8, 4'd9, 4'd10, 8'(i)));
    write_word(8'h48, enc(4'hF, 4'd0, 4'd0, 4'd0, 8'h00));
    start = 1'b1; start_pc = 8'h40;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== idle_vec(8'h00, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL reset_mid_run: got %h want %h", obs, idle_vec(8'h00, 1'b0, 1'b0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs !== idle_vec(8'h00, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL idle_after_mid_reset: got %h want %h", obs, idle_vec(8'h00, 1'b0, 1'b0));
    end
    run_program(8'h40, 1'b0, 1);
    vectors++;
    if (iss_slot.size() != 8) begin
      miscompares++;
      $display("FAIL imem_kept: got issues=%0d want 8", iss_slot.size());
    end
  endtask

  task automatic test_random();
    int          len;
    logic [7:0]  spc;
    for (int it = 0; it < 25; it++) begin
      len = $urandom_range(3, 12);
      spc = 8'($urandom);
      for (int i = 0; i < len; i++)
        write_word(spc + 8'(i), enc(4'($urandom_range(0, 14)), 4'($urandom % 4), 4'($urandom % 4),
                                    4'($urandom % 4), 8'($urandom)));
      write_word(spc + 8'(len), enc(4'hF, 4'($urandom), 4'($urandom), 4'($urandom), 8'($urandom)));
      run_program(spc, 1'b1, len);
    end
  endtask

  initial begin
    test_reset();
    test_independent();
    test_raw_hazard();
    test_wrap();
    test_restart();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_fetch_decode.md
# pipe_fetch_decode

Instruction fetch and decode stage that sits directly upstream of the 4-stage register/ALU/writeback/store pipeline and drives its `rs1`, `rs2`, `rd`, `func` and `addr` inputs. It holds a loadable 256×24 instruction memory, steps a program counter, and splits each word into operand fields. Because the downstream pipeline has no forwarding, this stage inserts NOP bubbles on read-after-write hazards. It starts on a pulse and stops on a HALT opcode.

## Interface
- `BUBBLE_ADDR`, 8'hFF: store address placed on `addr` during a bubble; this memory word is reserved as scratch.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `imem_we`  in  1  instruction memory write strobe; honoured in any state.
- `imem_waddr`  in  8  instruction memory write address.
- `imem_wdata`  in  24  instruction word: [23:20] func, [19:16] rd, [15:12] rs1, [11:8] rs2, [7:0] addr.
- `start`  in  1  one-cycle pulse that begins execution at `start_pc`.
- `start_pc`  in  8  first PC, sampled with `start`.
- `rs1`, `rs2`, `rd`, `func`  out  4 each  registered decoded fields to the downstream stage.
- `addr`  out  8  registered store address.
- `issue_valid`  out  1  high for one cycle for each real instruction issued.
- `pc`  out  8  current program counter.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in HALT.

## Operation
- States: IDLE, RUN, HALT. Reset puts the block in IDLE.
- IDLE, `start`=1: `pc`←`start_pc`, go to RUN.
- HALT, `start`=1: same as IDLE; restart is allowed. `start` in RUN is ignored.
- RUN, each cycle: read `imem[pc]` combinationally and decode it.
  - func=4'hF (HALT): issue a bubble, hold `pc`, go to HALT.
  - Hazard: issue a bubble and hold `pc`.
  - Otherwise: register the fields, `issue_valid`=1, `pc`←`pc`+1. The PC wraps 8'hFF→8'h00.
- Bubble (NOP) encoding: func=4'd3, rs1=rs2=rd=0, addr=`BUBBLE_ADDR`, `issue_valid`=0. It is emitted in every non-issuing cycle, including IDLE and HALT.
- Scoreboard: two entries {valid, rd}, for the last two issue slots.
  - Shifts every cycle.
  - Entry 0 takes {`issue_valid`, `rd`} of the slot just driven.
  - Bubbles enter as invalid.
- Hazard condition: the decoded rs1 or rs2 equals the rd of any valid entry. The check is conservative: both sources are compared for every func.
- Simultaneous `imem_we` to the address being fetched: the fetch sees the old word, and the write lands at the clock edge.
- Reset mid-operation clears the state, PC, scoreboard and outputs immediately. The instruction memory is not cleared.

## Timing
- Reset values:
  - `rs1`=`rs2`=`rd`=0, `func`=3, `addr`=`BUBBLE_ADDR`.
  - `issue_valid`=0, `pc`=0, `busy`=0, `done`=0.
- Latency: instruction at `pc` appears on the outputs 1 cycle after the edge where it is fetched.
- Issue timing:
  - `start` at edge N → first issue at edge N+2 (N+1 loads the PC and enters RUN; N+2 issues).
  - With no hazards, one issue per cycle.
- Hazard timing: a dependent instruction issues no earlier than 3 slots after its producer (2 bubbles). This matches the producer's writeback two stages downstream.
- `done` rises the cycle after the HALT word is fetched and stays high until `start` or reset.
- `busy` and `done` are never both high.

## Configuration
- `PIPE_HAZARD_STALL_EN` defined: scoreboard and RAW interlock active as above.
- Not defined: no scoreboard logic; every non-HALT instruction in RUN issues back-to-back. Software must place NOPs itself.

## Test plan
- Reset mid-RUN (`rst_n` low at an arbitrary point) → all outputs at reset values within the same cycle; IDLE on release.
- Independent stream:
  - Program: imem[0..3] = {0,1,2,3}, {0,4,5,6}, {1,7,8,9}, HALT.
  - `start` with `start_pc`=0 → three consecutive `issue_valid` pulses, `rd`=1,4,7.
  - Then `done`=1 with `pc`=3.
- RAW hazard:
  - Program: imem[0]={0,1,2,3}, imem[1]={0,4,1,5}, imem[2]=HALT.
  - With the macro → issue, bubble, bubble, issue (two bubbles, each with `addr`=8'hFF).
  - Without the macro → back-to-back issue.
- Wrap-around:
  - Program: `start_pc`=8'hFE; imem[FE], imem[FF], imem[00] independent; imem[01]=HALT.
  - → `pc` sequence FE, FF, 00, 01; three issues.
- Restart and write: after HALT, write imem[0]=HALT, then `start`=1 with `start_pc`=0 → `busy` for 1 cycle, `done` again, zero issues.
